// File: rtl/collatz_pkg.sv
// Shared constants and helpers for the Collatz lane dispatcher.
package collatz_pkg;

    localparam int DATA_W = 32;

    // Result value a lane reports when it cannot produce a trajectory count.
    localparam logic [DATA_W-1:0] COLLATZ_ERR = 32'h2BAD2BAD;

    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned n_lanes);
        return (ptr >= n_lanes - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_ptr.sv
// Wrapping round-robin pointer over 0..N-1, stepped once per advance pulse.
module rr_ptr
    import collatz_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    output logic [W-1:0] ptr
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= W'(ptr_next(32'(ptr), N));
        end
    end

endmodule

// File: rtl/collatz_dispatcher.sv
// Round-robin dispatcher for a pool of Collatz lanes; results leave in input order
// through one registered output stage.
module collatz_dispatcher
    import collatz_pkg::*;
#(
    parameter int N_LANES = 4,
    parameter int LANE_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [DATA_W-1:0]         in_TDATA,
    input  logic                      in_TVALID,
    output logic                      in_TREADY,
    output logic [DATA_W*N_LANES-1:0] lane_TDATA,
    output logic [N_LANES-1:0]        lane_TVALID,
    input  logic [N_LANES-1:0]        lane_TREADY,
    input  logic [DATA_W*N_LANES-1:0] res_TDATA,
    input  logic [N_LANES-1:0]        res_TVALID,
    output logic [N_LANES-1:0]        res_TREADY,
    output logic [DATA_W-1:0]         out_TDATA,
    output logic                      out_TVALID,
    input  logic                      out_TREADY,
    output logic                      idle,
    output logic [31:0]               done_count,
    output logic [15:0]               err_count,
    output logic                      stray_err
);

    logic [LANE_W-1:0]  dp;
    logic [LANE_W-1:0]  cp;
    logic [N_LANES-1:0] busy;
    logic [N_LANES-1:0] busy_next;

    logic              dp_busy;
    logic              dp_ready;
    logic              cp_busy;
    logic              cp_valid;
    logic [DATA_W-1:0] cp_data;

    logic dispatch_fire;
    logic collect_fire;
    logic out_free;
    logic out_fire;
    logic stray_hit;

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        dp_busy  = 1'b0;
        dp_ready = 1'b0;
        cp_busy  = 1'b0;
        cp_valid = 1'b0;
        cp_data  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (LANE_W'(i) == dp) begin
                dp_busy  = busy[i];
                dp_ready = lane_TREADY[i];
            end
            if (LANE_W'(i) == cp) begin
                cp_busy  = busy[i];
                cp_valid = res_TVALID[i];
                cp_data  = res_TDATA[DATA_W*i +: DATA_W];
            end
        end
    end

    assign in_TREADY     = enable && !dp_busy && dp_ready;
    assign dispatch_fire = in_TVALID && in_TREADY;
    assign out_free      = !out_TVALID || out_TREADY;
    assign collect_fire  = cp_busy && cp_valid && out_free;
    assign out_fire      = out_TVALID && out_TREADY;
    assign stray_hit     = |(res_TVALID & ~busy);
    assign lane_TDATA    = {N_LANES{in_TDATA}};
    assign idle          = (busy == '0) && !out_TVALID;

    // Busy is read from the current register, so a lane freed this cycle is only
    // offered to the dispatcher from the next cycle on.
    always_comb begin
        lane_TVALID = '0;
        res_TREADY  = '0;
        busy_next   = busy;
        for (int i = 0; i < N_LANES; i++) begin
            lane_TVALID[i] = enable && in_TVALID && !busy[i] && (LANE_W'(i) == dp);
            res_TREADY[i]  = (LANE_W'(i) == cp) && busy[i] && out_free;
            if (dispatch_fire && (LANE_W'(i) == dp)) begin
                busy_next[i] = 1'b1;
            end
            if (collect_fire && (LANE_W'(i) == cp)) begin
                busy_next[i] = 1'b0;
            end
        end
    end

    rr_ptr #(
        .N (N_LANES),
        .W (LANE_W)
    ) u_dp_ptr (
        .clk     (clk),
        .rst     (rst),
        .advance (dispatch_fire),
        .ptr     (dp)
    );

    rr_ptr #(
        .N (N_LANES),
        .W (LANE_W)
    ) u_cp_ptr (
        .clk     (clk),
        .rst     (rst),
        .advance (collect_fire),
        .ptr     (cp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Output register: loads on collect, otherwise drains when the sink accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_TDATA  <= '0;
            out_TVALID <= 1'b0;
        end else if (collect_fire) begin
            out_TDATA  <= cp_data;
            out_TVALID <= 1'b1;
        end else if (out_TREADY) begin
            out_TVALID <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_count <= '0;
            err_count  <= '0;
        end else if (out_fire) begin
            done_count <= done_count + 32'd1;
            if ((out_TDATA == COLLATZ_ERR) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stray_err <= 1'b0;
        end else if (stray_hit) begin
            stray_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_collatz_dispatcher.sv
// Self-checking bench: latency-programmable lane models plus an in-order result scoreboard.
module tb_collatz_dispatcher;

    localparam int N           = 4;
    localparam int SEND_BUDGET = 500;
    localparam logic [31:0] ERR_WORD = 32'h2BAD2BAD;

    logic            clk;
    logic            rst;
    logic            enable;
    logic [31:0]     in_TDATA;
    logic            in_TVALID;
    logic            in_TREADY;
    logic [32*N-1:0] lane_TDATA;
    logic [N-1:0]    lane_TVALID;
    logic [N-1:0]    lane_TREADY;
    logic [32*N-1:0] res_TDATA;
    logic [N-1:0]    res_TVALID;
    logic [N-1:0]    res_TREADY;
    logic [31:0]     out_TDATA;
    logic            out_TVALID;
    logic            out_TREADY;
    logic            idle;
    logic [31:0]     done_count;
    logic [15:0]     err_count;
    logic            stray_err;

    int n_checks = 0;
    int n_errors = 0;
    int disp_cnt = 0;
    int n_delivered = 0;

    logic [31:0] exp_q[$];

    int          lat[N];
    bit          lat_rand = 0;
    bit          rand_ready = 0;
    logic [N-1:0] stray_inj;
    bit          sender_done;

    logic [N-1:0] m_hold;
    int           m_cnt[N];
    logic [31:0]  m_res[N];

    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;

    collatz_dispatcher #(
        .N_LANES (N),
        .LANE_W  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .in_TDATA    (in_TDATA),
        .in_TVALID   (in_TVALID),
        .in_TREADY   (in_TREADY),
        .lane_TDATA  (lane_TDATA),
        .lane_TVALID (lane_TVALID),
        .lane_TREADY (lane_TREADY),
        .res_TDATA   (res_TDATA),
        .res_TVALID  (res_TVALID),
        .res_TREADY  (res_TREADY),
        .out_TDATA   (out_TDATA),
        .out_TVALID  (out_TVALID),
        .out_TREADY  (out_TREADY),
        .idle        (idle),
        .done_count  (done_count),
        .err_count   (err_count),
        .stray_err   (stray_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] collatz_steps(input logic [31:0] n);
        longint unsigned x;
        int unsigned     s;
        if (n == 0) return ERR_WORD;
        x = n;
        s = 0;
        while (x != 1) begin
            if (x[0]) x = 3 * x + 1;
            else      x = x >> 1;
            s++;
        end
        return s;
    endfunction

    // Lane models: accept a number, wait the programmed latency, present the count.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_hold[i] <= 1'b0;
                m_cnt[i]  <= 0;
                m_res[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_hold[i]) begin
                    if (m_cnt[i] > 0) m_cnt[i] <= m_cnt[i] - 1;
                    else if (res_TREADY[i]) m_hold[i] <= 1'b0;
                end else if (lane_TVALID[i] && lane_TREADY[i]) begin
                    m_hold[i] <= 1'b1;
                    m_res[i]  <= collatz_steps(lane_TDATA[32*i +: 32]);
                    m_cnt[i]  <= lat_rand ? int'($urandom_range(0, 6)) : lat[i];
                end
            end
        end
    end

    always_comb begin
        res_TDATA   = '0;
        res_TVALID  = '0;
        lane_TREADY = '0;
        for (int i = 0; i < N; i++) begin
            res_TDATA[32*i +: 32] = m_res[i];
            res_TVALID[i]         = (m_hold[i] && (m_cnt[i] == 0)) || stray_inj[i];
            lane_TREADY[i]        = !m_hold[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: scoreboard pop, hold-stability check and dispatch counting, all at negedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(out_TVALID), 1);
                    check("hold_data", out_TDATA, prev_data);
                end
                if (out_TVALID && out_TREADY) begin
                    n_delivered++;
                    if (exp_q.size() == 0) check("out_unexpected", 32'(exp_q.size()), 1);
                    else                   check("out_data", out_TDATA, exp_q.pop_front());
                end
                for (int i = 0; i < N; i++) begin
                    if (lane_TVALID[i] && lane_TREADY[i]) disp_cnt++;
                end
                prev_stall = out_TVALID && !out_TREADY;
                prev_data  = out_TDATA;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_TREADY = ($urandom_range(0, 9) < 7);
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lat(input int v);
        for (int i = 0; i < N; i++) lat[i] = v;
    endtask

    // Called just after a posedge; returns just after the edge that took the number.
    task automatic send(input logic [31:0] v);
        int waited = 0;
        in_TDATA  = v;
        in_TVALID = 1'b1;
        @(negedge clk);
        while (!in_TREADY && waited < SEND_BUDGET) begin
            @(negedge clk);
            waited++;
        end
        if (in_TREADY) exp_q.push_back(collatz_steps(v));
        else           check("send_timeout", 32'(in_TREADY), 1);
        @(posedge clk);
        #1;
        in_TVALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        bit reached = 0;
        while (!reached && n < budget) begin
            @(negedge clk);
            n++;
            if (idle && exp_q.size() == 0) reached = 1;
        end
        check(tag, 32'(reached), 1);
    endtask

    initial begin
        int d0;
        int nd0;
        int w;

        rst        = 1'b0;
        enable     = 1'b1;
        in_TVALID  = 1'b0;
        in_TDATA   = '0;
        out_TREADY = 1'b1;
        stray_inj  = '0;
        set_lat(0);
        #1;
        check("rst_out_valid", 32'(out_TVALID), 0);
        check("rst_out_data", out_TDATA, 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_done", done_count, 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_stray", 32'(stray_err), 0);
        check("rst_in_ready", 32'(in_TREADY), 1);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        align();

        // Ordering across unequal lane latencies: expect 111, 8, 16, 7.
        lat = '{40, 5, 10, 2};
        send(27);
        send(6);
        send(7);
        send(3);
        wait_idle(300, "order_idle");
        check("order_done_count", done_count, 4);
        check("order_idle_flag", 32'(idle), 1);

        // Full stall with the sink blocked.
        align();
        set_lat(30);
        out_TREADY  = 1'b0;
        d0          = disp_cnt;
        sender_done = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) send(32'(100 + k));
                sender_done = 1;
            end
        join_none
        repeat (15) @(negedge clk);
        check("stall_disp4", 32'(disp_cnt - d0), 4);
        check("stall_in_ready", 32'(in_TREADY), 0);
        repeat (60) @(negedge clk);
        check("stall_disp5", 32'(disp_cnt - d0), 5);
        check("stall_out_valid", 32'(out_TVALID), 1);
        check("stall_in_ready2", 32'(in_TREADY), 0);
        align();
        out_TREADY = 1'b1;
        w = 0;
        while (!sender_done && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("stall_sender_done", 32'(sender_done), 1);
        wait_idle(300, "stall_idle");
        check("stall_disp6", 32'(disp_cnt - d0), 6);

        // Random sink backpressure with random lane latencies.
        align();
        lat_rand   = 1;
        rand_ready = 1;
        nd0        = n_delivered;
        for (int k = 0; k < 100; k++) send($urandom_range(1, 1000));
        rand_ready = 0;
        out_TREADY = 1'b1;
        wait_idle(2000, "bp_idle");
        check("bp_count", 32'(n_delivered - nd0), 100);
        lat_rand = 0;

        // Error sentinel counting and saturation.
        align();
        set_lat(0);
        send(0);
        wait_idle(100, "err_idle");
        check("err_one", 32'(err_count), 1);
        align();
        for (int k = 0; k < 66000; k++) send(0);
        wait_idle(1000, "err_flood_idle");
        check("err_saturated", 32'(err_count), 32'h0000FFFF);
        check("done_total", done_count, 32'(n_delivered));

        // Drain with enable low while a new number is pending.
        align();
        set_lat(20);
        d0  = disp_cnt;
        nd0 = n_delivered;
        send(9);
        send(10);
        send(11);
        enable    = 1'b0;
        in_TDATA  = 12;
        in_TVALID = 1'b1;
        repeat (5) @(negedge clk);
        check("drain_in_ready", 32'(in_TREADY), 0);
        check("drain_lane_valid", 32'(lane_TVALID), 0);
        wait_idle(200, "drain_idle");
        check("drain_disp", 32'(disp_cnt - d0), 3);
        check("drain_delivered", 32'(n_delivered - nd0), 3);
        align();
        in_TVALID = 1'b0;
        enable    = 1'b1;

        // Result from a lane that holds no job.
        check("stray_before", 32'(stray_err), 0);
        stray_inj = 4'b0100;
        @(negedge clk);
        check("stray_ready", 32'(res_TREADY[2]), 0);
        align();
        stray_inj = '0;
        @(negedge clk);
        check("stray_set", 32'(stray_err), 1);
        repeat (5) @(negedge clk);
        check("stray_sticky", 32'(stray_err), 1);
        check("stray_no_out", 32'(out_TVALID), 0);

        // Asynchronous reset in the middle of a stalled stream.
        align();
        set_lat(0);
        out_TREADY = 1'b0;
        send(5);
        send(6);
        send(7);
        repeat (3) @(negedge clk);
        check("rst_mid_pre_valid", 32'(out_TVALID), 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_TVALID), 0);
        check("rst_mid_out_data", out_TDATA, 0);
        check("rst_mid_idle", 32'(idle), 1);
        check("rst_mid_done", done_count, 0);
        check("rst_mid_err", 32'(err_count), 0);
        check("rst_mid_stray", 32'(stray_err), 0);
        check("rst_mid_res_ready", 32'(res_TREADY), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(idle), 1);
        check("post_rst_out_valid", 32'(out_TVALID), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
